cluster_icache_flush_sequencer: RTL and testbench



---
 rtl/cluster_icache_flush_sequencer.sv | 159 +++++++++++++++
 tb/tb_cluster_icache_flush_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_icache_flush_sequencer.sv
// Round-robin icache flush sequencer: L1 flush, then per-port L0 flush, per granted request.
// Optional per-phase watchdog enabled by defining CLUSTER_ICACHE_FLUSH_TIMEOUT_EN.
module cluster_icache_flush_sequencer #(
   parameter int unsigned NR_FETCH_PORTS = 4,
   parameter int unsigned NR_REQUESTERS  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic [NR_REQUESTERS-1:0]                 req_valid_i,
   output logic [NR_REQUESTERS-1:0]                 req_ready_o,
   input  logic [NR_REQUESTERS*NR_FETCH_PORTS-1:0]  req_l0_mask_i,
   input  logic [NR_REQUESTERS-1:0]                 req_l1_i,
   output logic [NR_REQUESTERS-1:0]                 done_o,
   output logic                                     l1_flush_valid_o,
   input  logic                                     l1_flush_ready_i,
   output logic [NR_FETCH_PORTS-1:0]                l0_flush_valid_o,
   input  logic [NR_FETCH_PORTS-1:0]                l0_flush_ready_i,
   input  logic                                     enable_prefetch_i,
   output logic                                     enable_prefetch_o,
   output logic                                     busy_o,
   output logic [15:0]                              flush_count_o,
   input  logic                                     timeout_clr_i,
   output logic                                     timeout_o
);

   localparam int unsigned OW = (NR_REQUESTERS > 1) ? $clog2(NR_REQUESTERS) : 1;

   typedef enum logic [1:0] {IDLE, L1, L0, DONE} state_e;

   state_e                    state_q, state_d;
   logic [OW-1:0]             rr_q, rr_d, owner_q, owner_d;
   logic [NR_FETCH_PORTS-1:0] mask_q, mask_d;
   logic [15:0]               flush_count_q;
   logic                      gnt_valid, gnt_l1, count_en, timeout_fire, flush_ok;
   logic [OW-1:0]             gnt_idx;
   logic [NR_FETCH_PORTS-1:0] gnt_mask;
   logic [NR_REQUESTERS-1:0]  gnt_onehot;

   // Pass 0 scans requesters at or above rr_q, pass 1 wraps to those below it.
   always_comb begin
      gnt_valid  = 1'b0;
      gnt_idx    = '0;
      gnt_mask   = '0;
      gnt_l1     = 1'b0;
      gnt_onehot = '0;
      for (int unsigned pass = 0; pass < 2; pass++) begin
         for (int unsigned j = 0; j < NR_REQUESTERS; j++) begin
            if (!gnt_valid && req_valid_i[j] && ((pass == 0) == (j >= 32'(rr_q)))) begin
               gnt_valid     = 1'b1;
               gnt_idx       = OW'(j);
               gnt_mask      = req_l0_mask_i[j*NR_FETCH_PORTS +: NR_FETCH_PORTS];
               gnt_l1        = req_l1_i[j];
               gnt_onehot[j] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      owner_d  = owner_q;
      mask_d   = mask_q;
      count_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               owner_d = gnt_idx;
               mask_d  = gnt_mask;
               rr_d    = (32'(gnt_idx) == NR_REQUESTERS - 1) ? '0 : gnt_idx + 1'b1;
               if (gnt_l1)              state_d = L1;
               else if (gnt_mask != '0) state_d = L0;
               else                     state_d = DONE;
            end
         end
         L1: begin
            if (l1_flush_ready_i)  state_d = (mask_q != '0) ? L0 : DONE;
            else if (timeout_fire) state_d = DONE;
         end
         L0: begin
            mask_d = mask_q & ~l0_flush_ready_i;
            if ((mask_q & ~l0_flush_ready_i) == '0) state_d = DONE;
            else if (timeout_fire)                   state_d = DONE;
         end
         DONE: begin
            count_en = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         rr_q          <= '0;
         owner_q       <= '0;
         mask_q        <= '0;
         flush_count_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         mask_q  <= mask_d;
         if (count_en && flush_ok && flush_count_q != 16'hFFFF)
            flush_count_q <= flush_count_q + 16'd1;
      end
   end

`ifdef CLUSTER_ICACHE_FLUSH_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] phase_cnt_q;
   logic          to_flush_q, timeout_q, phase_done;

   assign phase_done   = (state_q == L1) ? l1_flush_ready_i
                                         : ((mask_q & ~l0_flush_ready_i) == '0);
   assign timeout_fire = (state_q == L1 || state_q == L0) && !phase_done &&
                         (phase_cnt_q == CW'(TIMEOUT_CYCLES - 1));
   assign flush_ok     = !to_flush_q;
   assign timeout_o    = timeout_q;

   // Any state change restarts the count, so each of L1 and L0 gets a full budget.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         phase_cnt_q <= '0;
         to_flush_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         phase_cnt_q <= (state_d != state_q) ? '0 : phase_cnt_q + 1'b1;
         if (state_q == IDLE && gnt_valid) to_flush_q <= 1'b0;
         else if (timeout_fire)            to_flush_q <= 1'b1;
         if (timeout_fire)       timeout_q <= 1'b1;
         else if (timeout_clr_i) timeout_q <= 1'b0;
      end
   end
`else
   logic unused_timeout_cfg;

   assign timeout_fire       = 1'b0;
   assign flush_ok           = 1'b1;
   assign timeout_o          = 1'b0;
   assign unused_timeout_cfg = timeout_clr_i | (TIMEOUT_CYCLES == 0);
`endif

   always_comb begin
      for (int unsigned j = 0; j < NR_REQUESTERS; j++)
         done_o[j] = (state_q == DONE) && (32'(owner_q) == j);
   end

   assign req_ready_o       = (state_q == IDLE) ? gnt_onehot : '0;
   assign l1_flush_valid_o  = (state_q == L1);
   assign l0_flush_valid_o  = (state_q == L0) ? mask_q : '0;
   assign busy_o            = (state_q != IDLE);
   assign enable_prefetch_o = enable_prefetch_i & ~busy_o;
   assign flush_count_o     = flush_count_q;

endmodule

// File: tb/tb_cluster_icache_flush_sequencer.sv
// Self-checking bench for cluster_icache_flush_sequencer against a job-level reference model.
// Watchdog scenarios run only when CLUSTER_ICACHE_FLUSH_TIMEOUT_EN is defined.
module tb_cluster_icache_flush_sequencer;
   localparam int NP = 4;
   localparam int NR = 3;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_ready;
   logic [NR*NP-1:0]  req_mask = '0;
   logic [NR-1:0]     req_l1 = '0;
   logic [NR-1:0]     done;
   logic              l1_valid;
   logic              l1_ready = 1'b0;
   logic [NP-1:0]     l0_valid;
   logic [NP-1:0]     l0_ready = '0;
   logic              pf_en = 1'b0;
   logic              pf_out;
   logic              busy;
   logic [15:0]       flush_count;
   logic              to_clr = 1'b0;
   logic              to_flag;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a pending job described by what is still owed to it.
   bit          m_busy;
   int          m_owner, m_rr, m_count, m_cnt, m_last_grant;
   bit          m_l1, m_timeout, m_timed;
   bit [NP-1:0] m_mask;

   cluster_icache_flush_sequencer #(
      .NR_FETCH_PORTS(NP),
      .NR_REQUESTERS (NR),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .req_l0_mask_i    (req_mask),
      .req_l1_i         (req_l1),
      .done_o           (done),
      .l1_flush_valid_o (l1_valid),
      .l1_flush_ready_i (l1_ready),
      .l0_flush_valid_o (l0_valid),
      .l0_flush_ready_i (l0_ready),
      .enable_prefetch_i(pf_en),
      .enable_prefetch_o(pf_out),
      .busy_o           (busy),
      .flush_count_o    (flush_count),
      .timeout_clr_i    (to_clr),
      .timeout_o        (to_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int m_pick();
      for (int k = 0; k < NR; k++) begin
         int idx = (m_rr + k) % NR;
         if (req_valid[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_rr = 0; m_count = 0; m_cnt = 0;
      m_l1 = 0; m_mask = '0; m_timeout = 0; m_timed = 0; m_last_grant = -1;
   endtask

   task automatic check_outputs();
      int g;
      int exp_ready, exp_done;
      g         = m_busy ? -1 : m_pick();
      exp_ready = (g >= 0) ? (1 << g) : 0;
      exp_done  = (m_busy && !m_l1 && m_mask == 0) ? (1 << m_owner) : 0;
      check("req_ready", 32'(req_ready), exp_ready);
      check("done", 32'(done), exp_done);
      check("l1_valid", 32'(l1_valid), 32'(m_busy && m_l1));
      check("l0_valid", 32'(l0_valid), (m_busy && !m_l1) ? 32'(m_mask) : 0);
      check("busy", 32'(busy), 32'(m_busy));
      check("prefetch", 32'(pf_out), 32'(pf_en && !m_busy));
      check("flush_count", 32'(flush_count), m_count);
      check("timeout", 32'(to_flag), 32'(m_timeout));
   endtask

   task automatic model_edge();
      bit complete, fire;
      int g;
      fire = 0;
      m_last_grant = -1;
      if (!m_busy) begin
         g = m_pick();
         if (g >= 0) begin
            m_busy = 1; m_owner = g; m_l1 = req_l1[g]; m_mask = req_mask[g*NP +: NP];
            m_rr = (g + 1) % NR; m_timed = 0; m_cnt = 0; m_last_grant = g;
         end
      end else if (m_l1 || m_mask != 0) begin
         complete = m_l1 ? l1_ready : ((m_mask & ~l0_ready) == 0);
`ifdef CLUSTER_ICACHE_FLUSH_TIMEOUT_EN
         if (!complete && m_cnt == TO - 1) begin
            fire = 1; m_l1 = 0; m_mask = '0; m_timed = 1;
         end
`endif
         if (!fire) begin
            if (m_l1) begin
               if (complete) begin m_l1 = 0; m_cnt = 0; end
               else m_cnt++;
            end else begin
               m_mask = m_mask & ~l0_ready;
               m_cnt++;
            end
         end
      end else begin
         if (!m_timed && m_count < 65535) m_count++;
         m_busy = 0;
      end
`ifdef CLUSTER_ICACHE_FLUSH_TIMEOUT_EN
      if (fire) m_timeout = 1;
      else if (to_clr) m_timeout = 0;
`endif
   endtask

   // Inputs are driven just after a negedge; check, let the edge happen, advance the model.
   task automatic cycle();
      #1;
      check_outputs();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic set_req(input int r, input bit l1, input logic [NP-1:0] mask);
      req_valid    = '0;
      req_valid[r] = 1'b1;
      req_l1[r]    = l1;
      req_mask[r*NP +: NP] = mask;
   endtask

   task automatic drive_random();
      for (int r = 0; r < NR; r++) begin
         if (!req_valid[r]) begin
            if ($urandom_range(0, 2) == 0) req_valid[r] = 1'b1;
         end else if (m_last_grant == r && $urandom_range(0, 1) == 0) begin
            req_valid[r] = 1'b0;
         end
         req_mask[r*NP +: NP] = NP'($urandom);
         req_l1[r]            = 1'($urandom_range(0, 1));
      end
      l1_ready = ($urandom_range(0, 2) != 0);
      l0_ready = NP'($urandom);
      pf_en    = 1'($urandom_range(0, 1));
      to_clr   = ($urandom_range(0, 7) == 0);
   endtask

   initial begin
      logic [NP-1:0] l0_sched [7];
      l0_sched = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
      model_reset();

      #12;
      check("rst_ready", 32'(req_ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_count", 32'(flush_count), 0);
      check("rst_timeout", 32'(to_flag), 0);
      @(negedge clk);
      rst = 1'b0;

      // Full request from requester 0, zero-wait targets.
      l1_ready = 1'b1; l0_ready = '1; pf_en = 1'b1;
      set_req(0, 1'b1, 4'b1111);
      cycle();
      req_valid = '0;
      for (int i = 0; i < 4; i++) cycle();
      check("full_count", 32'(flush_count), 1);

      // Requester 1, L0 only, ports completing on different cycles.
      l1_ready = 1'b0; l0_ready = '0;
      set_req(1, 1'b0, 4'b0101);
      cycle();
      req_valid = '0;
      for (int i = 1; i < 7; i++) begin
         l0_ready = l0_sched[i];
         cycle();
      end

      // Two requesters continuously valid with empty requests.
      l0_ready = '0;
      req_valid = 3'b011; req_l1 = '0; req_mask = '0;
      for (int i = 0; i < 12; i++) cycle();
      req_valid = '0;
      cycle();

      // L1 target stalls for 10 cycles.
      pf_en = 1'b1; l1_ready = 1'b0; l0_ready = '1;
      set_req(0, 1'b1, 4'b0011);
      cycle();
      req_valid = '0;
      for (int i = 0; i < 10; i++) cycle();
      l1_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle();

      // Reset asserted while in L0.
      l1_ready = 1'b0; l0_ready = '0;
      set_req(2, 1'b0, 4'b1111);
      cycle();
      req_valid = '0;
      cycle();
      rst = 1'b1;
      #1;
      check("rst_mid_l0", 32'(l0_valid), 0);
      check("rst_mid_busy", 32'(busy), 0);
      check("rst_mid_l1", 32'(l1_valid), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      req_valid = '1; req_mask = '0; req_l1 = '0;
      #1;
      check("post_rst_grant", 32'(req_ready), 1);
      cycle();
      req_valid = '0;
      for (int i = 0; i < 2; i++) cycle();

`ifdef CLUSTER_ICACHE_FLUSH_TIMEOUT_EN
      // Stuck L0 target trips the watchdog.
      begin
         int count_before;
         count_before = m_count;
         l0_ready = '0; to_clr = 1'b0;
         set_req(0, 1'b0, 4'b1111);
         cycle();
         req_valid = '0;
         for (int i = 0; i < 12; i++) cycle();
         check("wd_flag", 32'(to_flag), 1);
         check("wd_count", 32'(flush_count), 32'(count_before));
         to_clr = 1'b1;
         cycle();
         to_clr = 1'b0;
         #1;
         check("wd_clear", 32'(to_flag), 0);
      end
`endif

      for (int i = 0; i < 3000; i++) begin
         drive_random();
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
